// File: rtl/pp_nbuf_pkg.sv
// Shared types and width helpers for the N-deep ping-pong buffer stage.
package pp_nbuf_pkg;

  // Buffer indices carried through the read pipeline never exceed this width.
  localparam int MAX_PTR_W = 8;

  function automatic int PTR_W(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int CNT_W(input int n);
    return $clog2(n) + 1;
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [MAX_PTR_W-1:0] buf_idx;
  } rd_pipe_t;

endpackage

// File: rtl/pp_nbuf_ctrl.sv
// Pointer, occupancy and handshake control for pp_nbuf (no datapath).
// Sticky error flags exist only when PP_NBUF_ERR_EN is defined.
module pp_nbuf_ctrl
  import pp_nbuf_pkg::*;
#(
  parameter int BUF_NUM = 2,
  localparam int PW     = PTR_W(BUF_NUM),
  localparam int CW     = CNT_W(BUF_NUM)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_wen,
  input  logic          wr_done,
  input  logic          rd_ren,
  input  logic          rd_done,
  output logic          wr_ready,
  output logic          rd_valid,
  output logic          wr_acc,
  output logic          rd_acc,
  output logic [PW-1:0] wp,
  output logic [PW-1:0] rp,
  output logic [CW-1:0] buf_cnt,
  output logic          err_ovf,
  output logic          err_udf
);

  logic wr_commit;
  logic rd_release;

  assign wr_ready   = (buf_cnt < CW'(BUF_NUM));
  assign rd_valid   = (buf_cnt != '0);
  assign wr_acc     = wr_wen & wr_ready;
  assign rd_acc     = rd_ren & rd_valid;
  assign wr_commit  = wr_done & wr_ready;
  assign rd_release = rd_done & rd_valid;

  // BUF_NUM is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp      <= '0;
      rp      <= '0;
      buf_cnt <= '0;
    end else begin
      if (wr_commit)  wp <= wp + PW'(1);
      if (rd_release) rp <= rp + PW'(1);
      case ({wr_commit, rd_release})
        2'b10:   buf_cnt <= buf_cnt + CW'(1);
        2'b01:   buf_cnt <= buf_cnt - CW'(1);
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

`ifdef PP_NBUF_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      err_ovf <= err_ovf | ((wr_wen | wr_done) & ~wr_ready);
      err_udf <= err_udf | ((rd_ren | rd_done) & ~rd_valid);
    end
  end
`else
  assign err_ovf = 1'b0;
  assign err_udf = 1'b0;
`endif

endmodule

// File: rtl/ram_bank.sv
// Lane-split simple dual-port RAM with LATENCY-cycle registered read.
// STAGE identifies the encoder pipeline stage that owns the bank.
module ram_bank #(
  parameter int BANK_NUM        = 4,
  parameter int BANK_DATA_WIDTH = 272,
  parameter int ADDR_WIDTH      = 11,
  parameter int LATENCY         = 1,
  parameter int STAGE           = 2
) (
  input  logic                       clk,
  input  logic                       wen,
  input  logic [ADDR_WIDTH-1:0]      waddr,
  input  logic [BANK_DATA_WIDTH-1:0] wdata,
  input  logic                       ren,
  input  logic [ADDR_WIDTH-1:0]      raddr,
  output logic [BANK_DATA_WIDTH-1:0] rdata
);

  localparam int LANE_W = BANK_DATA_WIDTH / BANK_NUM;

  if (STAGE >= 0) begin : g_stage
    for (genvar gi = 0; gi < BANK_NUM; gi++) begin : g_lane
      logic [LANE_W-1:0] mem [2**ADDR_WIDTH];
      logic [LANE_W-1:0] rd_q [LATENCY];

      always_ff @(posedge clk) begin
        if (wen) mem[waddr] <= wdata[gi*LANE_W +: LANE_W];
      end

      always_ff @(posedge clk) begin
        if (ren) rd_q[0] <= mem[raddr];
        for (int i = 1; i < LATENCY; i++) rd_q[i] <= rd_q[i-1];
      end

      assign rdata[gi*LANE_W +: LANE_W] = rd_q[LATENCY-1];
    end
  end else begin : g_no_stage
    assign rdata = '0;
  end

endmodule

// File: rtl/pp_nbuf.sv
// N-deep ping-pong buffer stage with decoupled producer/consumer handshakes.
// Optional sticky error flags via PP_NBUF_ERR_EN.
module pp_nbuf
  import pp_nbuf_pkg::*;
#(
  parameter int DATA_WIDTH = 68,
  parameter int LANES      = 4,
  parameter int ADDR_WIDTH = 11,
  parameter int BUF_NUM    = 2,
  parameter int LATENCY    = 1,
  parameter int STAGE      = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_wen,
  input  logic [ADDR_WIDTH-1:0]             wr_waddr,
  input  logic [DATA_WIDTH*LANES-1:0]       wr_wdata,
  input  logic                              wr_done,
  output logic                              wr_ready,
  input  logic                              rd_ren,
  input  logic [ADDR_WIDTH-1:0]             rd_raddr,
  input  logic                              rd_done,
  output logic                              rd_valid,
  output logic [DATA_WIDTH*LANES-1:0]       rd_rdata,
  output logic                              rd_rvalid,
  output logic [CNT_W(BUF_NUM)-1:0]         buf_cnt,
  output logic                              err_ovf,
  output logic                              err_udf
);

  localparam int WW = DATA_WIDTH * LANES;
  localparam int PW = PTR_W(BUF_NUM);

  logic          wr_acc;
  logic          rd_acc;
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [WW-1:0] bank_rdata [BUF_NUM];
  rd_pipe_t      pipe_reg [LATENCY];
  rd_pipe_t      pipe_out;

  pp_nbuf_ctrl #(.BUF_NUM(BUF_NUM)) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_wen   (wr_wen),
    .wr_done  (wr_done),
    .rd_ren   (rd_ren),
    .rd_done  (rd_done),
    .wr_ready (wr_ready),
    .rd_valid (rd_valid),
    .wr_acc   (wr_acc),
    .rd_acc   (rd_acc),
    .wp       (wp),
    .rp       (rp),
    .buf_cnt  (buf_cnt),
    .err_ovf  (err_ovf),
    .err_udf  (err_udf)
  );

  for (genvar gi = 0; gi < BUF_NUM; gi++) begin : g_buf
    ram_bank #(
      .BANK_NUM        (LANES),
      .BANK_DATA_WIDTH (WW),
      .ADDR_WIDTH      (ADDR_WIDTH),
      .LATENCY         (LATENCY),
      .STAGE           (STAGE)
    ) u_bank (
      .clk   (clk),
      .wen   (wr_acc && (wp == PW'(gi))),
      .waddr (wr_waddr),
      .wdata (wr_wdata),
      .ren   (rd_acc && (rp == PW'(gi))),
      .raddr (rd_raddr),
      .rdata (bank_rdata[gi])
    );
  end

  // Buffer index travels alongside the RAM latency so the mux picks the right bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) pipe_reg[i] <= '0;
    end else begin
      pipe_reg[0] <= '{valid: rd_acc, buf_idx: MAX_PTR_W'(rp)};
      for (int i = 1; i < LATENCY; i++) pipe_reg[i] <= pipe_reg[i-1];
    end
  end

  assign pipe_out  = pipe_reg[LATENCY-1];
  assign rd_rvalid = pipe_out.valid;

  always_comb begin
    rd_rdata = '0;
    for (int i = 0; i < BUF_NUM; i++) begin
      if (pipe_out.valid && (pipe_out.buf_idx == MAX_PTR_W'(i))) rd_rdata = bank_rdata[i];
    end
  end

endmodule

// File: tb/tb_pp_nbuf.sv
// Directed, scoreboard-based bench for pp_nbuf (BUF_NUM=4, LATENCY=2).
// Error-flag expectations follow PP_NBUF_ERR_EN.
module tb_pp_nbuf;
  localparam int DW  = 68;
  localparam int LN  = 4;
  localparam int W   = DW * LN;
  localparam int AW  = 4;
  localparam int BN  = 4;
  localparam int LAT = 2;
  localparam int CW  = $clog2(BN) + 1;
`ifdef PP_NBUF_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_wen, wr_done, rd_ren, rd_done;
  logic [AW-1:0] wr_waddr, rd_raddr;
  logic [W-1:0]  wr_wdata, rd_rdata;
  logic          wr_ready, rd_valid, rd_rvalid, err_ovf, err_udf;
  logic [CW-1:0] buf_cnt;

  always #5 clk = ~clk;

  pp_nbuf #(.DATA_WIDTH(DW), .LANES(LN), .ADDR_WIDTH(AW), .BUF_NUM(BN),
            .LATENCY(LAT), .STAGE(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_wen(wr_wen), .wr_waddr(wr_waddr), .wr_wdata(wr_wdata), .wr_done(wr_done),
    .wr_ready(wr_ready),
    .rd_ren(rd_ren), .rd_raddr(rd_raddr), .rd_done(rd_done), .rd_valid(rd_valid),
    .rd_rdata(rd_rdata), .rd_rvalid(rd_rvalid), .buf_cnt(buf_cnt),
    .err_ovf(err_ovf), .err_udf(err_udf)
  );

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] mem_m [BN][2**AW];
  int wp_m = 0, rp_m = 0, cnt_m = 0;
  int cyc = 0;
  int vectors = 0, errs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mkdata(input int t);
    logic [W-1:0] d = '0;
    for (int l = 0; l < LN; l++) d[l*DW +: DW] = DW'(t * 16 + l);
    return d;
  endfunction

  // One clock of stimulus, called at a falling edge; model advances alongside.
  task automatic step(input logic wen, input int wa, input logic [W-1:0] wd, input logic wdn,
                      input logic ren, input int ra, input logic rdn);
    logic commit, release_b;
    wr_wen = wen; wr_waddr = AW'(wa); wr_wdata = wd; wr_done = wdn;
    rd_ren = ren; rd_raddr = AW'(ra); rd_done = rdn;
    if (ren && cnt_m != 0) q.push_back('{mem_m[rp_m][ra], cyc + LAT});
    if (wen && cnt_m < BN) mem_m[wp_m][wa] = wd;
    commit    = wdn && (cnt_m < BN);
    release_b = rdn && (cnt_m != 0);
    if (commit)    wp_m = (wp_m + 1) % BN;
    if (release_b) rp_m = (rp_m + 1) % BN;
    cnt_m = cnt_m + int'(commit) - int'(release_b);
    @(negedge clk);
    wr_wen = 0; wr_done = 0; rd_ren = 0; rd_done = 0;
  endtask

  task automatic drain(input string tag);
    repeat (LAT + 1) @(negedge clk);
    chk(tag, W'(q.size()), W'(0));
  endtask

  // Scoreboard: every rd_rvalid pops one expected word and checks its cycle.
  always @(negedge clk) begin
    if (rd_rvalid) begin
      chk("rvalid_expected", W'(q.size() != 0), W'(1));
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("rd_rdata", rd_rdata, e.data);
        chk("rd_latency", W'(cyc), W'(e.due));
      end
    end else begin
      chk("rdata_gated", rd_rdata, '0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; wr_wen = 0; wr_done = 0; rd_ren = 0; rd_done = 0;
    wr_waddr = '0; rd_raddr = '0; wr_wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("reset_wr_ready", W'(wr_ready), W'(1));
    chk("reset_rd_valid", W'(rd_valid), W'(0));
    chk("reset_buf_cnt", W'(buf_cnt), W'(0));
    chk("reset_err_ovf", W'(err_ovf), W'(0));
    chk("reset_err_udf", W'(err_udf), W'(0));

    // Single buffer round trip.
    for (int a = 0; a < 4; a++) step(1, a, W'(a + 1), 0, 0, 0, 0);
    step(0, 0, '0, 1, 0, 0, 0);
    chk("rt_buf_cnt", W'(buf_cnt), W'(1));
    chk("rt_rd_valid", W'(rd_valid), W'(1));
    for (int a = 0; a < 4; a++) step(0, 0, '0, 0, 1, a, a == 3);
    drain("rt_drain");
    chk("rt_buf_cnt_after", W'(buf_cnt), W'(0));

    // Fill every buffer; write on the commit cycle lands in the committed buffer.
    for (int b = 0; b < BN; b++) begin
      for (int a = 0; a < 4; a++) step(1, a, mkdata(10 + b * 4 + a), a == 3, 0, 0, 0);
    end
    chk("full_buf_cnt", W'(buf_cnt), W'(BN));
    chk("full_wr_ready", W'(wr_ready), W'(0));
    chk("full_err_ovf_pre", W'(err_ovf), W'(0));
    step(1, 0, {W{1'b1}} & W'(8'hFF), 1, 0, 0, 0);
    chk("ovf_buf_cnt", W'(buf_cnt), W'(BN));
    chk("ovf_err_ovf", W'(err_ovf), W'(EXP_ERR));
    for (int b = 0; b < BN; b++) begin
      for (int a = 0; a < 4; a++) step(0, 0, '0, 0, 1, a, a == 3);
    end
    drain("fill_drain");
    chk("fill_buf_cnt_after", W'(buf_cnt), W'(0));
    chk("fill_wr_ready_after", W'(wr_ready), W'(1));

    // Wrap-around with per-iteration tags.
    for (int it = 0; it < 10; it++) begin
      step(1, 0, mkdata(100 + it), 0, 0, 0, 0);
      step(1, 1, mkdata(200 + it), 1, 0, 0, 0);
      step(0, 0, '0, 0, 1, 0, 0);
      step(0, 0, '0, 0, 1, 1, 1);
      chk("wrap_buf_cnt", W'(buf_cnt), W'(0));
    end
    drain("wrap_drain");

    // Simultaneous commit and release with buf_cnt=1.
    step(1, 0, mkdata(300), 0, 0, 0, 0);
    step(1, 1, mkdata(301), 1, 0, 0, 0);
    step(1, 0, mkdata(310), 0, 0, 0, 0);
    step(1, 1, mkdata(311), 0, 0, 0, 0);
    chk("simul_buf_cnt_pre", W'(buf_cnt), W'(1));
    step(1, 2, mkdata(312), 1, 1, 0, 1);
    chk("simul_buf_cnt", W'(buf_cnt), W'(1));
    chk("simul_rd_valid", W'(rd_valid), W'(1));
    for (int a = 0; a < 3; a++) step(0, 0, '0, 0, 1, a, a == 2);
    drain("simul_drain");
    chk("simul_buf_cnt_after", W'(buf_cnt), W'(0));

    // Underflow.
    step(0, 0, '0, 0, 1, 0, 1);
    repeat (LAT + 1) @(negedge clk);
    chk("udf_rd_rvalid", W'(rd_rvalid), W'(0));
    chk("udf_rd_rdata", rd_rdata, '0);
    chk("udf_buf_cnt", W'(buf_cnt), W'(0));
    chk("udf_err_udf", W'(err_udf), W'(EXP_ERR));
    drain("udf_drain");

    // Reset one cycle after an accepted read: no rd_rvalid may follow.
    step(1, 0, mkdata(400), 1, 0, 0, 0);
    rd_ren = 1; rd_raddr = '0;
    @(negedge clk);
    rd_ren = 0;
    rst_n = 0;
    wp_m = 0; rp_m = 0; cnt_m = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    chk("rst_buf_cnt", W'(buf_cnt), W'(0));
    chk("rst_wr_ready", W'(wr_ready), W'(1));
    chk("rst_rd_valid", W'(rd_valid), W'(0));
    chk("rst_err_ovf", W'(err_ovf), W'(0));
    chk("rst_err_udf", W'(err_udf), W'(0));
    drain("rst_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
